ntt_butterfly: RTL

// Radix-2 butterfly datapath for the NTT/INTT engine, built on the modular add/sub/mult/x_4 units.
// - Consumes coefficient pairs and a twiddle factor; produces the butterfly result pair.
// - Supports Cooley-Tukey (forward NTT) and Gentleman-Sande (inverse NTT) with optional /4 scaling.
// - Fully pipelined streaming stage: one pair per cycle, fixed latency, mode carried per sample.

---
 rtl/ntt_butterfly.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/ntt_butterfly.sv
// ntt_butterfly -- radix-2 NTT/INTT butterfly, fully pipelined, one pair per cycle.
//   mode=0 (CT): a' = a + w*b, b' = a - w*b                   (mod Q)
//   mode=1 (GS): a' = a + b,   b' = (a - b)*w, optional * 4^-1 (mod Q)
// Latency is L = MULT_LAT+2 cycles in both modes:
//   pre-stage reg (GS add/sub, CT passthrough) -> MULT_LAT-stage modmul -> post logic + output reg.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   in_valid, mode, scale sample strobe and per-sample mode tags
//   in_a, in_b, in_w      coefficients and twiddle, all < Q
//   out_valid, out_a/b    result strobe and fully reduced result pair
//   inflight              accepted-but-not-yet-emitted sample count
module ntt_butterfly #(
  parameter int                WIDTH    = 23,
  parameter logic [WIDTH-1:0]  Q        = 23'd8380417,
  parameter int                MULT_LAT = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             mode,
  input  logic             scale,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_w,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [3:0]       inflight
);

  localparam int L = MULT_LAT + 2;
  localparam logic [2*WIDTH-1:0] Q_WIDE = (2*WIDTH)'(Q);

  typedef struct packed {
    logic mode;
    logic scale;  // already qualified with mode, so CT never scales
  } tag_t;

  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, Q}) s = s - {1'b0, Q};
    return s[WIDTH-1:0];
  endfunction

  function automatic logic [WIDTH-1:0] mod_sub(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
    logic [WIDTH:0] d;
    d = {1'b0, x} - {1'b0, y};
    if (d[WIDTH]) d = d + {1'b0, Q};  // borrow: wrap back into [0, Q-1]
    return d[WIDTH-1:0];
  endfunction

  // x * 2^-1 mod Q: odd values get Q added first (Q is odd) so the shift is exact.
  function automatic logic [WIDTH-1:0] mod_half(input logic [WIDTH-1:0] x);
    logic [WIDTH:0] h;
    h = x[0] ? ({1'b0, x} + {1'b0, Q}) : {1'b0, x};
    return h[WIDTH:1];
  endfunction

  // Control pipe: index 0 = pre-stage, L-1 = output register.
  logic [L-1:0]              vld_pipe_q, vld_pipe_d;
  tag_t [L-2:0]              tag_pipe_q, tag_pipe_d;
  // Data pipe (no reset; only ever observed when valid-tagged).
  logic [WIDTH-1:0]          pre_comp_q, pre_comp_d;  // CT: a, GS: a+b
  logic [WIDTH-1:0]          pre_x_q, pre_x_d;        // CT: b, GS: a-b
  logic [WIDTH-1:0]          pre_w_q, pre_w_d;
  logic [2*WIDTH-1:0]        mul_p_q, mul_p_d;        // raw product, first multiplier stage
  logic [MULT_LAT-1:1][WIDTH-1:0] mres_q, mres_d;     // reduced product, delayed to MULT_LAT
  logic [MULT_LAT-1:0][WIDTH-1:0] comp_q, comp_d;     // companion aligned with multiplier
  logic [WIDTH-1:0]          out_a_q, out_a_d, out_b_q, out_b_d;
  logic [3:0]                inflight_q, inflight_d;

  logic [WIDTH-1:0] post_t, post_c, post_a, post_b;
  tag_t             post_tag;

  always_comb begin
    vld_pipe_d = {vld_pipe_q[L-2:0], in_valid};
    tag_pipe_d = {tag_pipe_q[L-3:0], tag_t'{mode: mode, scale: mode & scale}};

    if (mode) begin
      pre_comp_d = mod_add(in_a, in_b);
      pre_x_d    = mod_sub(in_a, in_b);
    end else begin
      pre_comp_d = in_a;
      pre_x_d    = in_b;
    end
    pre_w_d = in_w;

    mul_p_d   = {{WIDTH{1'b0}}, pre_x_q} * {{WIDTH{1'b0}}, pre_w_q};
    mres_d    = mres_q;
    mres_d[1] = WIDTH'(mul_p_q % Q_WIDE);
    for (int k = 2; k < MULT_LAT; k++) mres_d[k] = mres_q[k-1];
    comp_d    = comp_q;
    comp_d[0] = pre_comp_q;
    for (int k = 1; k < MULT_LAT; k++) comp_d[k] = comp_q[k-1];

    post_t   = mres_q[MULT_LAT-1];
    post_c   = comp_q[MULT_LAT-1];
    post_tag = tag_pipe_q[L-2];
    if (!post_tag.mode) begin
      post_a = mod_add(post_c, post_t);
      post_b = mod_sub(post_c, post_t);
    end else if (post_tag.scale) begin
      post_a = mod_half(mod_half(post_c));
      post_b = mod_half(mod_half(post_t));
    end else begin
      post_a = post_c;
      post_b = post_t;
    end
    // Bubbles load zero so stale pipe data never reaches the outputs.
    out_a_d = vld_pipe_q[L-2] ? post_a : '0;
    out_b_d = vld_pipe_q[L-2] ? post_b : '0;

    case ({in_valid, vld_pipe_q[L-1]})
      2'b10:   inflight_d = inflight_q + 4'd1;
      2'b01:   inflight_d = inflight_q - 4'd1;
      default: inflight_d = inflight_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe_q <= '0;
      tag_pipe_q <= '0;
      out_a_q    <= '0;
      out_b_q    <= '0;
      inflight_q <= '0;
    end else begin
      vld_pipe_q <= vld_pipe_d;
      tag_pipe_q <= tag_pipe_d;
      out_a_q    <= out_a_d;
      out_b_q    <= out_b_d;
      inflight_q <= inflight_d;
    end
  end

  always_ff @(posedge clk) begin
    pre_comp_q <= pre_comp_d;
    pre_x_q    <= pre_x_d;
    pre_w_q    <= pre_w_d;
    mul_p_q    <= mul_p_d;
    mres_q     <= mres_d;
    comp_q     <= comp_d;
  end

  assign out_valid = vld_pipe_q[L-1];
  assign out_a     = out_a_q;
  assign out_b     = out_b_q;
  assign inflight  = inflight_q;

endmodule
